pipeline_wall: RTL

PIPELINE_WALL -- requirements
Module: pipeline_wall

---
 rtl/pipeline_wall.sv | 99 +++++++++
 1 files changed

// File: rtl/pipeline_wall.sv
// pipeline_wall: DEPTH-stage valid/ready register wall with bubble collapse, flush and optional
// even parity (define PIPELINE_WALL_PARITY_EN). Empty-pipe latency DEPTH cycles; stalls fill bubbles before dropping in_ready.
module pipeline_wall #(
  parameter int WIDTH = 75,
  parameter int DEPTH = 3,
  localparam int OCCW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCCW-1:0]  occupancy,
  output logic             parity_err
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] dat [DEPTH];
  logic             full_dn;

  // A stage moves on unless every stage below it is full and the output is stalled.
  // Computed per stage from the valid bits directly, so there is no ripple through adv.
  always_comb begin
    full_dn = 1'b1;
    adv     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      full_dn = 1'b1;
      for (int j = i + 1; j < DEPTH; j++) begin
        full_dn = full_dn & vld[j];
      end
      adv[i] = vld[i] & (~full_dn | out_ready);
    end
  end

  assign in_ready = ~flush & (~vld[0] | adv[0]);

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCCW'(vld[i]);
    end
  end

`ifdef PIPELINE_WALL_PARITY_EN
  logic [DEPTH-1:0] par;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
`ifdef PIPELINE_WALL_PARITY_EN
      par <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) vld[i] <= 1'b0;
        else       vld[i] <= load[i] | (vld[i] & ~adv[i]);
      end
      // Data moves with the token even during flush; empty-stage contents are don't-care.
      if (load[0]) dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) dat[i] <= dat[i-1];
      end
`ifdef PIPELINE_WALL_PARITY_EN
      if (load[0]) par[0] <= ^in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) par[i] <= par[i-1];
      end
`endif
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

`ifdef PIPELINE_WALL_PARITY_EN
  assign parity_err = out_valid & ((^out_data) != par[DEPTH-1]);
`else
  assign parity_err = 1'b0;
`endif

endmodule
